ms_event_scheduler: RTL and testbench
=====================================

# ms_event_scheduler

Shares the 1 ms tick from the FX clock divider between several effect engines (LFO, delay tap, envelope step, arpeggiator). Each channel has a programmable period in milliseconds. When a period expires, the channel raises a pending event. A round-robin arbiter serialises pending events onto one valid/ready event port that feeds the FX sequencer.

## Interface
- NUM_CH, 4, number of scheduled channels (2..8)
- PERIOD_W, 16, width of per-channel period in ms ticks
- clk  in  1  system clock (50 MHz)
- reset  in  1  one clock; reset is synchronous and active-high
- ms_tick  in  1  one-cycle pulse every millisecond from the divider
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  $clog2(NUM_CH)  channel being configured
- cfg_period  in  PERIOD_W  period in ms; 0 = channel disabled
- cfg_en  in  1  channel enable
- ev_valid  out  1  event offered
- ev_ch  out  $clog2(NUM_CH)  channel of offered event
- ev_ready  in  1  consumer accepts event
- overrun  out  NUM_CH  sticky per-channel flag: an expiry occurred while that channel's event was still pending
- ovr_clr  in  1  clears all overrun bits

## Operation
- Per-channel state: en, period, count (PERIOD_W), pending.
- Config write: period ← cfg_period, en ← cfg_en, count ← cfg_period−1, pending ← 0. The exception is the channel currently offered on ev_ch: its offer is held and completes normally.
- A channel is active when en=1 and period≠0. Inactive channels never decrement, expire or set pending.
- On ms_tick, for each active channel:
  - count==0: expire, set pending, count ← period−1.
  - Otherwise: count−1.
- Expiry while pending=1: overrun[ch] ← 1, pending stays 1 (events do not queue).
- FSM states:
  - IDLE: if any pending, pick via round-robin starting at rr_ptr, register ev_ch, go to OFFER.
  - OFFER: ev_valid=1, ev_ch stable. On ev_ready: clear pending[ev_ch] (unless re-expiring this cycle), rr_ptr ← ev_ch+1 mod NUM_CH, go to IDLE.
- Simultaneous handshake and expiry on the same channel: pending remains 1, no overrun.
- Simultaneous cfg_we and ms_tick on the same channel: config wins, no expiry.
- ovr_clr together with a new overrun on the same bit: bit ends 1.
- Reset mid-offer: ev_valid drops next cycle and no handshake is recorded.

## Timing
- Reset values:
  - ev_valid=0, ev_ch=0, overrun=0.
  - All en=0, period=0, count=0, pending=0.
  - rr_ptr=0, state=IDLE.
- Expiry at the ms_tick in cycle t gives pending=1 at t+1 and ev_valid=1 at t+2 when IDLE.
- Handshake at cycle h gives ev_valid=0 at h+1. The next offer comes no earlier than h+2 (one bubble). Peak throughput is one event per 2 cycles.
- ev_valid and ev_ch never change in OFFER until the handshake (except on reset).
- Period P yields an event every P ms ticks. The first event comes on the P-th ms_tick after the config write.

## Structure
- Shared package fx_pkg holds:
  - default NUM_CH and PERIOD_W constants
  - the scheduler state typedef (IDLE, OFFER)
- Sub-module rr_arbiter is combinational. Inputs: request vector and rr_ptr. Outputs: grant index and any_req.
- Per-channel counters are generated with a generate loop in the top.
- Target size is 150–250 lines.

## Test plan
- Period=3 on ch0, ev_ready tied 1, 10 ms_ticks: events exactly after ticks 3, 6, 9; ev_valid at tick cycle +2; overrun=0.
- ch0..ch3 all period=1, ev_ready=1: one ms_tick yields events in order 0, 1, 2, 3, each separated by one bubble; the next tick restarts at ch0.
- ch1 period=2, ev_ready held 0 over 4 ticks: single held offer with ev_ch=1; overrun[1]=1 after tick 4. Then ev_ready=1: one handshake, pending cleared. ovr_clr: overrun=0.
- Config write ch2 period=0 while its count=1: no further events. Rewrite period=5, en=1: first event after the 5th subsequent tick.
- Handshake on ch0 in the same cycle ch0 expires: pending stays 1, a second ch0 event is offered 2 cycles later, overrun[0]=0.
- Reset asserted during OFFER: ev_valid=0 and all pending=0 next cycle; no events until reconfigured.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared constants and scheduler state encoding for the FX event scheduler.
package fx_pkg;
  localparam int NUM_CH_DEF   = 4;
  localparam int PERIOD_W_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Zero latency; no backpressure of its own.
module rr_arbiter
  import fx_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   grant,
  output logic              any_req
);

  logic [CH_W-1:0] idx;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = CH_W'((int'(ptr) + k) % NUM_CH);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx;
      end
    end
  end

endmodule

// File: rtl/ms_event_scheduler.sv
// Per-channel ms period timers feeding a round-robin valid/ready event port.
// Expiry -> ev_valid two cycles later; offer is held until ev_ready, one bubble between offers.
module ms_event_scheduler
  import fx_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ms_tick,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_en,
  output logic                ev_valid,
  output logic [CH_W-1:0]     ev_ch,
  input  logic                ev_ready,
  output logic [NUM_CH-1:0]   overrun,
  input  logic                ovr_clr
);

  sched_state_t      state_q, state_d;
  logic [CH_W-1:0]   ev_ch_q, ev_ch_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] overrun_q, overrun_d;
  logic [NUM_CH-1:0] pending_vec;
  logic [NUM_CH-1:0] ovr_set_vec;
  logic [CH_W-1:0]   grant;
  logic              any_req;
  logic              hs;

  assign hs = (state_q == OFFER) && ev_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                en_q, en_d;
    logic                pending_q, pending_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic                cfg_hit, offered, active, expire;

    assign cfg_hit = cfg_we && (cfg_ch == CH_W'(i));
    assign offered = (state_q == OFFER) && (ev_ch_q == CH_W'(i));
    assign active  = en_q && (period_q != '0);
    // A config write to this channel overrides any tick in the same cycle.
    assign expire  = ms_tick && active && !cfg_hit && (count_q == '0);

    always_comb begin
      en_d      = en_q;
      period_d  = period_q;
      count_d   = count_q;
      pending_d = pending_q;
      if (cfg_hit) begin
        en_d     = cfg_en;
        period_d = cfg_period;
        count_d  = cfg_period - 1'b1;
        if (!offered) pending_d = 1'b0;
      end else if (ms_tick && active) begin
        count_d = (count_q == '0) ? period_q - 1'b1 : count_q - 1'b1;
      end
      if (expire) pending_d = 1'b1;
      else if (hs && offered) pending_d = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        en_q      <= 1'b0;
        period_q  <= '0;
        count_q   <= '0;
        pending_q <= 1'b0;
      end else begin
        en_q      <= en_d;
        period_q  <= period_d;
        count_q   <= count_d;
        pending_q <= pending_d;
      end
    end

    assign pending_vec[i] = pending_q;
    // An expiry landing on the handshake cycle re-arms the event rather than losing one.
    assign ovr_set_vec[i] = expire && pending_q && !(hs && offered);
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (pending_vec),
    .ptr     (rr_ptr_q),
    .grant   (grant),
    .any_req (any_req)
  );

  always_comb begin
    state_d  = state_q;
    ev_ch_d  = ev_ch_q;
    rr_ptr_d = rr_ptr_q;
    ev_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          ev_ch_d = grant;
          state_d = OFFER;
        end
      end
      OFFER: begin
        ev_valid = 1'b1;
        if (ev_ready) begin
          rr_ptr_d = (ev_ch_q == CH_W'(NUM_CH - 1)) ? '0 : ev_ch_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun_d = (ovr_clr ? '0 : overrun_q) | ovr_set_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ev_ch_q   <= '0;
      rr_ptr_q  <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      ev_ch_q   <= ev_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  assign ev_ch   = ev_ch_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_ms_event_scheduler.sv
// Scoreboard bench for ms_event_scheduler: expected events queued at stimulus time, popped on handshake.
module tb_ms_event_scheduler;
  localparam int NUM_CH   = 4;
  localparam int PERIOD_W = 16;
  localparam int CH_W     = 2;

  typedef struct {
    int ch;
    int cyc;
  } ev_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                ms_tick;
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [PERIOD_W-1:0] cfg_period;
  logic                cfg_en;
  logic                ev_valid;
  logic [CH_W-1:0]     ev_ch;
  logic                ev_ready;
  logic [NUM_CH-1:0]   overrun;
  logic                ovr_clr;

  int  n_chk  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  ev_t exp_q[$];
  ev_t e_pop;
  logic            prev_hold = 1'b0;
  logic [CH_W-1:0] prev_ch   = '0;

  ms_event_scheduler #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ms_tick    (ms_tick),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_en     (cfg_en),
    .ev_valid   (ev_valid),
    .ev_ch      (ev_ch),
    .ev_ready   (ev_ready),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Handshake monitor plus offer-stability check.
  always @(negedge clk) begin
    if (prev_hold) begin
      check_val("offer_hold_vld", int'(ev_valid), 1);
      check_val("offer_hold_ch", int'(ev_ch), int'(prev_ch));
    end
    if (!reset && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        check_val("ev_unexpected_ch", int'(ev_ch), -1);
      end else begin
        e_pop = exp_q.pop_front();
        check_val("ev_ch", int'(ev_ch), e_pop.ch);
        check_val("ev_cycle", cyc, e_pop.cyc);
      end
    end
    prev_hold = !reset && ev_valid && !ev_ready;
    prev_ch   = ev_ch;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic do_tick(output int t);
    ms_tick = 1'b1;
    t = cyc;
    step(1);
    ms_tick = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int period, input bit en);
    cfg_we     = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_period = PERIOD_W'(period);
    cfg_en     = en;
    step(1);
    cfg_we     = 1'b0;
  endtask

  task automatic push_ev(input int ch, input int c);
    ev_t e;
    e.ch  = ch;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_val("drain_timeout_left", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset      = 1'b1;
    ms_tick    = 1'b0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_en     = 1'b0;
    ev_ready   = 1'b0;
    ovr_clr    = 1'b0;
    step(2);
    reset = 1'b0;
    check_val("rst_ev_valid", int'(ev_valid), 0);
    check_val("rst_ev_ch", int'(ev_ch), 0);
    check_val("rst_overrun", int'(overrun), 0);

    // Period 3 on ch0, ready tied high: events after ticks 3, 6, 9.
    do_reset();
    ev_ready = 1'b1;
    cfg_write(0, 3, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      do_tick(t);
      if (k % 3 == 0) push_ev(0, t + 2);
      step(4);
    end
    drain(20);
    check_val("p3_overrun", int'(overrun), 0);

    // All four channels period 1: round-robin 0..3 with one bubble, restart at 0.
    do_reset();
    ev_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) cfg_write(c, 1, 1'b1);
    do_tick(t);
    for (int c = 0; c < NUM_CH; c++) push_ev(c, t + 2 + 2 * c);
    step(9);
    do_tick(t);
    for (int c = 0; c < NUM_CH; c++) push_ev(c, t + 2 + 2 * c);
    drain(30);
    check_val("rr_overrun", int'(overrun), 0);

    // ch1 period 2 with ready low: one held offer, overrun after tick 4.
    do_reset();
    ev_ready = 1'b0;
    cfg_write(1, 2, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      do_tick(t);
      step(2);
      if (k == 3) check_val("hold_no_ovr_yet", int'(overrun), 0);
    end
    check_val("hold_overrun", int'(overrun), 4'b0010);
    check_val("hold_valid", int'(ev_valid), 1);
    check_val("hold_ch", int'(ev_ch), 1);
    ev_ready = 1'b1;
    push_ev(1, cyc);
    step(4);
    check_val("hold_cleared_valid", int'(ev_valid), 0);
    check_val("hold_ovr_sticky", int'(overrun), 4'b0010);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    check_val("ovr_clr", int'(overrun), 0);

    // Disable ch2 mid-count, then reprogram to period 5.
    do_reset();
    ev_ready = 1'b1;
    cfg_write(2, 3, 1'b1);
    do_tick(t);
    step(2);
    cfg_write(2, 0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      do_tick(t);
      step(3);
    end
    check_val("disabled_valid", int'(ev_valid), 0);
    cfg_write(2, 5, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      do_tick(t);
      if (k == 5) push_ev(2, t + 2);
      step(4);
    end
    drain(20);

    // Handshake on ch0 in the same cycle ch0 expires again.
    do_reset();
    ev_ready = 1'b0;
    cfg_write(0, 1, 1'b1);
    do_tick(t);
    step(2);
    ev_ready = 1'b1;
    ms_tick  = 1'b1;
    push_ev(0, cyc);
    push_ev(0, cyc + 2);
    step(1);
    ms_tick = 1'b0;
    drain(10);
    check_val("hs_expire_overrun", int'(overrun), 0);

    // Reset during an offer drops it; nothing follows without reconfiguration.
    do_reset();
    ev_ready = 1'b0;
    cfg_write(1, 1, 1'b1);
    do_tick(t);
    step(1);
    check_val("pre_rst_valid", int'(ev_valid), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_val("post_rst_valid", int'(ev_valid), 0);
    check_val("post_rst_ch", int'(ev_ch), 0);
    ev_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_tick(t);
      step(3);
    end
    check_val("post_rst_idle", int'(ev_valid), 0);
    check_val("post_rst_overrun", int'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
